pmt_pulse_gen: RTL and testbench
================================

# pmt_pulse_gen

Programmable pulse-train transmitter that drives the time-bin photon counter's two inputs: a count pulse line (counted on its falling edge) and a bin-clear strobe (acting on its falling edge). It emits a clear strobe followed by exactly N pulses of programmable high and low width. It sits in the FPGA-PMT bench/self-test path, replacing the PMT discriminator output so bin counts can be checked against a known source.

## Interface
- CNT_W, 8, width of pulse count request and sent counter; matches counter output width
- HI_W, 8, width of high-time field
- LO_W, 16, width of low-time field
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminate train; sampled in CLR/HIGH/LOW
- n_pulses  in  CNT_W  number of pulses to emit; latched on accepted start
- high_cycles  in  HI_W  pulse high time in clk cycles; latched on start
- low_cycles  in  LO_W  pulse low time in clk cycles; latched on start
- pulse_out  out  1  count pulse line to counter
- bin_clr  out  1  clear strobe to counter
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- sent_count  out  CNT_W  falling edges emitted on pulse_out since last start

## Operation
- All outputs registered (Moore, decoded from state register); reset value of every output 0, state IDLE, latched fields 0.
- States: IDLE, CLR, HIGH, LOW, DONE.
- IDLE: start=1 latches n_pulses, high_cycles, low_cycles; clears sent_count; next CLR. start in any other state ignored.
- CLR: bin_clr=1 for exactly one cycle. Next HIGH if latched N>0, else DONE.
- HIGH: pulse_out=1 for Heff cycles, Heff = max(high_cycles,1). Then LOW; sent_count increments by 1 on the HIGH->LOW transition.
- LOW: pulse_out=0 for Leff cycles, Leff = max(low_cycles,1). Then HIGH if sent_count < N, else DONE.
- DONE: done=1, busy=1 for one cycle; next IDLE.
- Zero widths are promoted to 1 so the counter's edge detector always sees a high and a low sample.
- abort=1 in CLR/HIGH/LOW: next state IDLE, pulse_out and bin_clr 0 next cycle, done never asserted. Abort in HIGH produces a falling edge the counter will register, so sent_count increments for it; abort in LOW/CLR leaves sent_count unchanged. abort in IDLE/DONE ignored.
- abort and start same cycle in IDLE: start wins (abort not sampled in IDLE).
- sent_count holds its value in IDLE until next accepted start; no wrap possible since it never exceeds N ≤ 2^CNT_W-1.
- Width counters are internal down-counters sized HI_W / LO_W; no overflow.

## Timing
- start sampled at edge T: bin_clr=1 during cycle T+1; first pulse_out rise at T+2.
- Pulse k (k=0..N-1) high from T+2+k(Heff+Leff) for Heff cycles; period Heff+Leff.
- done=1 in cycle T+2+N(Heff+Leff); N=0 gives done at T+2.
- busy=1 from T+1 through the done cycle inclusive; next start accepted from the cycle after done.
- Abort sampled at edge A: outputs low and busy=0 from A+1.
- Asynchronous reset mid-train: pulse_out, bin_clr, busy, done, sent_count go 0 immediately; state IDLE on release.

## Test plan
- Reset asserted mid-run, released -> all outputs 0, state IDLE; start one cycle later accepted normally.
- start with N=3, H=2, L=3 at T -> bin_clr high T+1; pulse_out high T+2..3, T+7..8, T+12..13; done at T+17; sent_count=3; attached counter reads 3.
- start with N=0 -> bin_clr at T+1, done at T+2, pulse_out never high, sent_count=0.
- start with N=4, H=0, L=0 -> period 2 cycles, done at T+10, sent_count=4, counter reads 4.
- N=5, H=4, L=4, abort during second HIGH -> pulse_out low next cycle, sent_count=2, busy=0, no done; counter reads 2.
- start pulsed during HIGH of a running N=2 train -> ignored; train completes with sent_count=2 and only one done.

Source files
------------

// File: rtl/pmt_pulse_gen.sv
// -----------------------------------------------------------------------------
// pmt_pulse_gen
//
// Programmable pulse-train transmitter for the time-bin photon counter
// self-test path. A start request arms one train: a single-cycle bin-clear
// strobe, then exactly N pulses with programmable high and low widths, then a
// one-cycle done pulse. It stands in for the PMT discriminator so the counter's
// bin counts can be checked against a known source.
//
// The counter acts on falling edges of both lines, so every pulse needs at
// least one high and one low sample. Zero widths are therefore promoted to one
// cycle.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        asynchronous reset, active low
//   start        one-cycle request, only honoured in IDLE
//   abort        terminate the running train (CLR/HIGH/LOW only)
//   n_pulses     number of pulses, latched on an accepted start
//   high_cycles  pulse high time in clk cycles, latched on start
//   low_cycles   pulse low time in clk cycles, latched on start
//   pulse_out    count pulse line to the counter
//   bin_clr      bin-clear strobe to the counter
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse (never after an abort)
//   sent_count   falling edges emitted on pulse_out since the last start
// -----------------------------------------------------------------------------
module pmt_pulse_gen #(
  parameter int CNT_W = 8,
  parameter int HI_W  = 8,
  parameter int LO_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [HI_W-1:0]  high_cycles,
  input  logic [LO_W-1:0]  low_cycles,
  output logic             pulse_out,
  output logic             bin_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t state, state_next;

  // Latched train parameters. Widths are stored as reload values (effective
  // width minus one) so the down-counters simply run to zero.
  logic [CNT_W-1:0] n_lat;
  logic [HI_W-1:0]  hi_reload;
  logic [LO_W-1:0]  lo_reload;

  // Per-phase down-counters; zero means "last cycle of this phase".
  logic [HI_W-1:0]  hi_cnt;
  logic [LO_W-1:0]  lo_cnt;

  logic enter_high;
  logic enter_low;
  logic leave_high;
  logic accept_start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_CLR;
      end
      S_CLR: begin
        if (abort)            state_next = S_IDLE;
        else if (n_lat != '0) state_next = S_HIGH;
        else                  state_next = S_DONE;
      end
      S_HIGH: begin
        if (abort)             state_next = S_IDLE;
        else if (hi_cnt == '0) state_next = S_LOW;
      end
      S_LOW: begin
        // sent_count was bumped on the HIGH->LOW transition, so it already
        // includes the pulse that has just finished.
        if (abort)                  state_next = S_IDLE;
        else if (lo_cnt == '0)      state_next = (sent_count < n_lat) ? S_HIGH : S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept_start = (state == S_IDLE) && start;
  assign enter_high   = (state_next == S_HIGH) && (state != S_HIGH);
  assign enter_low    = (state_next == S_LOW)  && (state != S_LOW);
  // Leaving HIGH for any reason (normal end or abort) drops pulse_out and so
  // produces a falling edge the counter will register.
  assign leave_high   = (state == S_HIGH) && (state_next != S_HIGH);

  // ---------------------------------------------------------------------------
  // Parameter latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_lat     <= '0;
      hi_reload <= '0;
      lo_reload <= '0;
    end else if (accept_start) begin
      n_lat     <= n_pulses;
      hi_reload <= (high_cycles == '0) ? '0 : high_cycles - HI_W'(1);
      lo_reload <= (low_cycles  == '0) ? '0 : low_cycles  - LO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Phase width counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_cnt <= '0;
    end else if (enter_high) begin
      hi_cnt <= hi_reload;
    end else if ((state == S_HIGH) && (hi_cnt != '0)) begin
      hi_cnt <= hi_cnt - HI_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_cnt <= '0;
    end else if (enter_low) begin
      lo_cnt <= lo_reload;
    end else if ((state == S_LOW) && (lo_cnt != '0)) begin
      lo_cnt <= lo_cnt - LO_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Falling-edge count. Never exceeds the latched N, so it cannot wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_count <= '0;
    end else if (accept_start) begin
      sent_count <= '0;
    end else if (leave_high) begin
      sent_count <= sent_count + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered Moore outputs, decoded from the upcoming state so each output
  // flop holds exactly what the state register will hold after the edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_out <= 1'b0;
      bin_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_out <= (state_next == S_HIGH);
      bin_clr   <= (state_next == S_CLR);
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_pmt_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pmt_pulse_gen
//
// Self-checking bench for pmt_pulse_gen. Each train's expected per-cycle
// outputs are derived from the timing formulas (bin_clr at T+1, pulse k high
// from T+2+k*P for Heff cycles, done at T+2+N*P) and queued when the start is
// driven; the DUT outputs are popped and compared on every falling clock edge.
// A small model of the attached photon counter (counts pulse_out falling
// edges, cleared by the bin_clr falling edge) is checked after each train.
// -----------------------------------------------------------------------------
module tb_pmt_pulse_gen;

  localparam int CNT_W = 8;
  localparam int HI_W  = 8;
  localparam int LO_W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_pulses;
  logic [HI_W-1:0]  high_cycles;
  logic [LO_W-1:0]  low_cycles;
  logic             pulse_out;
  logic             bin_clr;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_count;

  typedef struct packed {
    logic             po;
    logic             bc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;
  } obs_t;

  obs_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   counter_model = 0;

  pmt_pulse_gen #(
    .CNT_W(CNT_W),
    .HI_W (HI_W),
    .LO_W (LO_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .n_pulses   (n_pulses),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .pulse_out  (pulse_out),
    .bin_clr    (bin_clr),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  // Attached photon counter model.
  always @(negedge pulse_out) counter_model = counter_model + 1;
  always @(negedge bin_clr)   counter_model = 0;

  // Run one train: queue expected rows, drive start, compare every cycle.
  // abort_c > 0 asserts abort during that cycle; start_c > 0 pulses a
  // (to-be-ignored) start with different parameters during that cycle.
  task automatic run_train(input string name, input int n, input int h,
                           input int l, input int abort_c, input int start_c);
    int   heff, leff, p, total, last, cnt, final_sent;
    logic prev_po;
    logic [CNT_W-1:0] prev_sent;
    obs_t r, act, ex;

    heff  = (h == 0) ? 1 : h;
    leff  = (l == 0) ? 1 : l;
    p     = heff + leff;
    total = 2 + n * p;
    last  = (abort_c > 0) ? abort_c + 1 : total + 1;
    prev_po   = 1'b0;
    prev_sent = '0;

    for (int c = 1; c <= last; c++) begin
      r = '0;
      if (abort_c > 0 && c == last) begin
        r.sent = prev_sent + CNT_W'(prev_po);
      end else begin
        r.bc   = (c == 1);
        r.busy = (c <= total);
        r.done = (c == total);
        if (c >= 2 && c < total) r.po = (((c - 2) % p) < heff);
        cnt = 0;
        for (int k = 0; k < n; k++) if (2 + k * p + heff <= c) cnt++;
        r.sent = CNT_W'(cnt);
      end
      prev_po   = r.po;
      prev_sent = r.sent;
      exp_q.push_back(r);
    end
    final_sent = int'(prev_sent);

    @(negedge clk);
    n_pulses    = CNT_W'(n);
    high_cycles = HI_W'(h);
    low_cycles  = LO_W'(l);
    start       = 1'b1;
    abort       = 1'b0;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      act = {pulse_out, bin_clr, busy, done, sent_count};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: scoreboard empty", name, c);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          tests_failed++;
          $display("FAIL %s cycle %0d: got po=%b clr=%b busy=%b done=%b sent=%0d, want po=%b clr=%b busy=%b done=%b sent=%0d",
                   name, c, act.po, act.bc, act.busy, act.done, act.sent,
                   ex.po, ex.bc, ex.busy, ex.done, ex.sent);
        end
      end
      if (c == abort_c) abort = 1'b1;
      if (c == start_c) begin
        start       = 1'b1;
        n_pulses    = CNT_W'(7);
        high_cycles = HI_W'(1);
        low_cycles  = LO_W'(1);
      end
    end
    start = 1'b0;
    abort = 1'b0;

    tests_run++;
    if (counter_model !== final_sent) begin
      tests_failed++;
      $display("FAIL %s counter: got %0d, want %0d", name, counter_model, final_sent);
    end
  endtask

  task automatic test_reset();
    obs_t act;
    // Reset state after power-on reset.
    act = {pulse_out, bin_clr, busy, done, sent_count};
    tests_run++;
    if (act !== obs_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_init: got %h, want 0", act);
    end
    // Start a train, then assert reset asynchronously mid-pulse.
    @(negedge clk);
    n_pulses = 8'd3; high_cycles = 8'd2; low_cycles = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    act = {pulse_out, bin_clr, busy, done, sent_count};
    tests_run++;
    if (act !== obs_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_async: got %h, want 0", act);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    act = {pulse_out, bin_clr, busy, done, sent_count};
    tests_run++;
    if (act !== obs_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_release: got %h, want 0", act);
    end
  endtask

  task automatic test_basic();
    run_train("basic_n3_h2_l3", 3, 2, 3, 0, 0);
  endtask

  task automatic test_zero_n();
    run_train("zero_n", 0, 5, 5, 0, 0);
  endtask

  task automatic test_zero_width();
    run_train("zero_width_n4", 4, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_train("abort_high", 5, 4, 4, 11, 0);
    run_train("abort_low", 3, 1, 5, 4, 0);
    run_train("abort_clr", 2, 2, 2, 1, 0);
  endtask

  task automatic test_start_ignored();
    run_train("start_ignored", 2, 3, 2, 0, 4);
  endtask

  task automatic test_back_to_back();
    run_train("b2b_a", 1, 1, 1, 0, 0);
    run_train("b2b_rand", int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 0, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    n_pulses = '0; high_cycles = '0; low_cycles = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_n();
    test_zero_width();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
